symm_sequencer: RTL and testbench

- Single-clock controller that sequences the 4x4 symmetric-orthogonalization datapath through its stages: mul1, norm, sqrt, sel, mul2/mul3, sub, mul4, abs and test.
- Replaces per-stage gated clocks with clock enables on one clock domain.
- Runs the sel..test refinement loop until the datapath reports orthogonality or an iteration limit is reached.
- Sits between the FastICA top-level control (go/busy/done) and the symm datapath stages.

---
 rtl/symm_pkg.sv | 77 +++++++
 rtl/symm_dwell_cnt.sv | 36 +++
 rtl/symm_sequencer.sv | 141 ++++++++++++++
 tb/tb_symm_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/symm_pkg.sv
// Shared types and helpers for the symmetric-orthogonalization sequencer:
// the FSM state encoding, the stage-enable bundle and the stage decode.
package symm_pkg;

   // Sequencer states; working states map one-to-one onto datapath stages
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_MUL1  = 4'd1,
      S_NORM  = 4'd2,
      S_SQRT  = 4'd3,
      S_SEL   = 4'd4,
      S_MUL23 = 4'd5,
      S_SUB   = 4'd6,
      S_MUL4  = 4'd7,
      S_ABS   = 4'd8,
      S_TEST  = 4'd9,
      S_DONE  = 4'd10
   } state_t;

   // One clock enable per datapath stage
   typedef struct packed {
      logic e_mul1;
      logic e_norm;
      logic e_sqrt;
      logic e_sel;
      logic e_mul2;
      logic e_mul3;
      logic e_sub;
      logic e_mul4;
      logic e_abs;
      logic e_test;
   } symm_en_t;

   // Stage counts of the first pass (mul1..test) and of a refinement pass (sel..test)
   localparam int N_STAGES_FIRST = 9;
   localparam int N_STAGES_LOOP  = 6;

   // Enable set belonging to a state; MUL23 drives both multipliers at once
   function automatic symm_en_t decode_en(input state_t s);
      symm_en_t e;
      e = '0;
      case (s)
         S_MUL1:  e.e_mul1 = 1'b1;
         S_NORM:  e.e_norm = 1'b1;
         S_SQRT:  e.e_sqrt = 1'b1;
         S_SEL:   e.e_sel  = 1'b1;
         S_MUL23: begin
            e.e_mul2 = 1'b1;
            e.e_mul3 = 1'b1;
         end
         S_SUB:   e.e_sub  = 1'b1;
         S_MUL4:  e.e_mul4 = 1'b1;
         S_ABS:   e.e_abs  = 1'b1;
         S_TEST:  e.e_test = 1'b1;
         default: e = '0;
      endcase
      return e;
   endfunction

   // Fixed stage order between MUL1 and TEST; anything else falls back to IDLE
   function automatic state_t next_stage(input state_t s);
      state_t n;
      case (s)
         S_MUL1:  n = S_NORM;
         S_NORM:  n = S_SQRT;
         S_SQRT:  n = S_SEL;
         S_SEL:   n = S_MUL23;
         S_MUL23: n = S_SUB;
         S_SUB:   n = S_MUL4;
         S_MUL4:  n = S_ABS;
         S_ABS:   n = S_TEST;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/symm_dwell_cnt.sv
// Stage dwell timer: loadable down-counter that flags the last cycle of a
// stage (count at zero). Holds at zero until the next load.
module symm_dwell_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         last_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load on a state change, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/symm_sequencer.sv
// Sequencer for the 4x4 symmetric-orthogonalization datapath. Walks the
// stages with per-stage clock enables on a single clock, then repeats the
// sel..test refinement loop until the test stage reports orthogonality or
// the pass budget runs out. All outputs are flops fed from the next state,
// so they change together with the state register and clear asynchronously.
module symm_sequencer
   import symm_pkg::*;
#(
   parameter int STAGE_CYC = 2,
   parameter int MAX_ITER  = 8,
   parameter int ITER_W    = 4
) (
   input  logic              clk_symm,
   input  logic              rst_symm_n,
   input  logic              go_symm,
   input  logic              is_orth,
   output logic              symm_busy,
   output logic              symm_done,
   output logic              symm_timeout,
   output logic [ITER_W-1:0] iter_count,
   output logic              en_mul1,
   output logic              en_norm,
   output logic              en_sqrt,
   output logic              en_sel,
   output logic              en_mul2,
   output logic              en_mul3,
   output logic              en_sub,
   output logic              en_mul4,
   output logic              en_abs,
   output logic              en_test,
   output logic              select
);

   localparam int              DW         = $clog2(STAGE_CYC + 1);
   localparam logic [DW-1:0]   DWELL_LOAD = DW'(STAGE_CYC - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                sel_q, sel_d;
   logic                tmo_q, tmo_d;
   symm_en_t            en_q;
   logic                busy_q;
   logic                done_q;
   logic                dwell_last;
   logic                dwell_load;

   // Every state change restarts the dwell timer for the new stage
   assign dwell_load = (state_d != state_q);

   symm_dwell_cnt #(
      .W (DW)
   ) u_dwell (
      .clk        (clk_symm),
      .rst_n      (rst_symm_n),
      .load_i     (dwell_load),
      .load_val_i (DWELL_LOAD),
      .last_o     (dwell_last)
   );

   // Next-state logic: start on go in IDLE, advance at the end of each dwell,
   // decide loop/finish from is_orth only on the last TEST cycle
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      sel_d   = sel_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (go_symm) begin
               state_d = S_MUL1;
               iter_d  = '0;
               sel_d   = 1'b0;
               tmo_d   = 1'b0;
            end
         end
         S_TEST: begin
            if (dwell_last) begin
               if (is_orth) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b0;
               end else if (iter_q == ITER_LAST) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b1;
               end else begin
                  state_d = S_SEL;
                  sel_d   = 1'b1;
                  iter_d  = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            if (dwell_last) begin
               state_d = next_stage(state_q);
            end
         end
      endcase
   end

   // State, loop bookkeeping and registered output decode
   always_ff @(posedge clk_symm or negedge rst_symm_n) begin
      if (!rst_symm_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         sel_q   <= 1'b0;
         tmo_q   <= 1'b0;
         en_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         sel_q   <= sel_d;
         tmo_q   <= tmo_d;
         en_q    <= decode_en(state_d);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign symm_busy    = busy_q;
   assign symm_done    = done_q;
   assign symm_timeout = tmo_q;
   assign iter_count   = iter_q;
   assign select       = sel_q;

   assign en_mul1 = en_q.e_mul1;
   assign en_norm = en_q.e_norm;
   assign en_sqrt = en_q.e_sqrt;
   assign en_sel  = en_q.e_sel;
   assign en_mul2 = en_q.e_mul2;
   assign en_mul3 = en_q.e_mul3;
   assign en_sub  = en_q.e_sub;
   assign en_mul4 = en_q.e_mul4;
   assign en_abs  = en_q.e_abs;
   assign en_test = en_q.e_test;

endmodule

// File: tb/tb_symm_sequencer.sv
// Directed bench for symm_sequencer with default parameters (STAGE_CYC=2,
// MAX_ITER=8, ITER_W=4). Cycle numbers are relative to the cycle in which
// go is presented (cycle 0); outputs are sampled on the falling edge.
module tb_symm_sequencer;

   logic       clk_symm   = 1'b0;
   logic       rst_symm_n = 1'b0;
   logic       go_symm    = 1'b0;
   logic       is_orth    = 1'b0;
   logic       symm_busy, symm_done, symm_timeout, select;
   logic [3:0] iter_count;
   logic       en_mul1, en_norm, en_sqrt, en_sel, en_mul2;
   logic       en_mul3, en_sub, en_mul4, en_abs, en_test;
   logic [9:0] en_vec;
   logic [17:0] all_vec;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_symm = ~clk_symm;

   assign en_vec  = {en_mul1, en_norm, en_sqrt, en_sel, en_mul2,
                     en_mul3, en_sub, en_mul4, en_abs, en_test};
   assign all_vec = {en_vec, symm_busy, symm_done, symm_timeout, select, iter_count};

   symm_sequencer #(
      .STAGE_CYC (2),
      .MAX_ITER  (8),
      .ITER_W    (4)
   ) dut (
      .clk_symm     (clk_symm),
      .rst_symm_n   (rst_symm_n),
      .go_symm      (go_symm),
      .is_orth      (is_orth),
      .symm_busy    (symm_busy),
      .symm_done    (symm_done),
      .symm_timeout (symm_timeout),
      .iter_count   (iter_count),
      .en_mul1      (en_mul1),
      .en_norm      (en_norm),
      .en_sqrt      (en_sqrt),
      .en_sel       (en_sel),
      .en_mul2      (en_mul2),
      .en_mul3      (en_mul3),
      .en_sub       (en_sub),
      .en_mul4      (en_mul4),
      .en_abs       (en_abs),
      .en_test      (en_test),
      .select       (select)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Enable pattern {mul1,norm,sqrt,sel,mul2,mul3,sub,mul4,abs,test} per stage index
   function automatic logic [9:0] stage_pat(input int s);
      case (s)
         0: return 10'b10_0000_0000;
         1: return 10'b01_0000_0000;
         2: return 10'b00_1000_0000;
         3: return 10'b00_0100_0000;
         4: return 10'b00_0011_0000;
         5: return 10'b00_0000_1000;
         6: return 10'b00_0000_0100;
         7: return 10'b00_0000_0010;
         8: return 10'b00_0000_0001;
         default: return 10'b0;
      endcase
   endfunction

   // Two cycles per stage: cycles 1..18 are the first pass, then 12-cycle loops from SEL
   function automatic logic [9:0] exp_en(input int c, input int done_c);
      int s;
      if (c < 1 || c >= done_c) return 10'b0;
      if (c <= 18) s = (c - 1) / 2;
      else         s = 3 + ((c - 19) % 12) / 2;
      return stage_pat(s);
   endfunction

   // One run from cycle 0 (caller is on a falling edge). conv = pass that reports
   // orthogonal, -1 for never. go is re-pulsed at cycles go_a/go_b. is_orth is also
   // raised on the first TEST cycle of every earlier pass, where it must be ignored.
   task automatic run(input int ncyc, input int conv, input int go_a, input int go_b);
      int done_c, orth_c, fin_iter, exp_iter;
      fin_iter = (conv >= 0) ? conv : 7;
      done_c   = 19 + 12 * fin_iter;
      orth_c   = (conv >= 0) ? done_c - 1 : 100000;
      go_symm  = 1'b1;
      is_orth  = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_symm);
         if (c >= done_c)  exp_iter = fin_iter;
         else if (c < 19)  exp_iter = 0;
         else              exp_iter = (c - 19) / 12 + 1;
         check($sformatf("en c%0d", c),   en_vec,       exp_en(c, done_c));
         check($sformatf("busy c%0d", c), symm_busy,    c <= done_c);
         check($sformatf("done c%0d", c), symm_done,    c == done_c);
         check($sformatf("iter c%0d", c), iter_count,   exp_iter);
         check($sformatf("sel c%0d", c),  select,       (c >= 19) && (done_c > 19));
         check($sformatf("tmo c%0d", c),  symm_timeout, (conv < 0) && (c >= done_c));
         go_symm = (c == go_a) || (c == go_b);
         is_orth = (c == orth_c) || (c >= 17 && (c - 17) % 12 == 0 && c < orth_c);
      end
      go_symm = 1'b0;
      is_orth = 1'b0;
   endtask

   // Quiet cycles with go low; status outputs must hold their final values
   task automatic idle_chk(input int n, input int e_iter, input logic e_tmo, input logic e_sel);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_symm);
         check($sformatf("idle en %0d", i),   {en_vec, symm_busy, symm_done}, 12'h0);
         check($sformatf("idle iter %0d", i), iter_count,   e_iter);
         check($sformatf("idle tmo %0d", i),  symm_timeout, e_tmo);
         check($sformatf("idle sel %0d", i),  select,       e_sel);
      end
   endtask

   initial begin
      // reset held for three cycles, then ten idle cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_symm);
         check($sformatf("in_reset %0d", i), all_vec, 18'h0);
      end
      rst_symm_n = 1'b1;
      idle_chk(10, 0, 1'b0, 1'b0);

      // single pass, orthogonal on pass 0: DONE at 19, idle at 20
      run(20, 0, -1, -1);
      idle_chk(2, 0, 1'b0, 1'b0);

      // converge on pass 2: SEL again at 19-20 and 31-32, DONE at 43
      run(44, 2, -1, -1);
      idle_chk(2, 2, 1'b0, 1'b1);

      // never orthogonal: timeout DONE at 103 with iter 7, flag held afterwards
      run(104, -1, -1, -1);
      idle_chk(3, 7, 1'b1, 1'b1);

      // go during busy (5) and during DONE (19) ignored; timeout cleared by new go
      run(20, 0, 5, 19);
      // go in the first idle cycle after DONE is a new run: mul1 at 21-22
      run(20, 0, -1, -1);

      // asynchronous reset mid-run during SUB of the second pass (cycle 23)
      go_symm = 1'b1;
      @(negedge clk_symm);
      go_symm = 1'b0;
      for (int c = 2; c <= 23; c++) begin
         is_orth = 1'b0;
         @(negedge clk_symm);
      end
      check("pre_rst en_sub", en_vec, 10'b00_0000_1000);
      check("pre_rst select", select, 1'b1);
      check("pre_rst iter",   iter_count, 4'd1);
      #2 rst_symm_n = 1'b0;
      #1;
      check("async_rst en",   en_vec, 10'h0);
      check("async_rst busy", symm_busy, 1'b0);
      check("async_rst all",  all_vec, 18'h0);
      @(negedge clk_symm);
      check("rst_hold all", all_vec, 18'h0);
      rst_symm_n = 1'b1;
      @(negedge clk_symm);
      check("post_rst all", all_vec, 18'h0);

      // clean restart: first SEL must take the sqrt path again, converge on pass 1
      run(32, 1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
